// File: rtl/nn_pkg.sv
// Shared types and helpers for the neural-network training datapath blocks.
// Holds the backward-pass FSM state type, the shift-and-saturate helper used
// at every column end, and the flat weight-vector index helper that keeps the
// weight layout identical to the forward layers.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } bwd_state_t;

  // Widest accumulator the helper below can take; callers sign-extend into it.
  localparam int SAT_W = 64;

  // Arithmetic right shift (floors toward -inf), then clamp to a signed
  // range of 'width' bits. Callers keep only the low 'width' bits.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] acc,
    input int                      frac,
    input int                      width
  );
    logic signed [SAT_W-1:0] shifted;
    logic signed [SAT_W-1:0] maxVal;
    logic signed [SAT_W-1:0] minVal;
    shifted = acc >>> frac;
    maxVal  = (64'sd1 <<< (width - 1)) - 64'sd1;
    minVal  = -(64'sd1 <<< (width - 1));
    if (shifted > maxVal) begin
      return maxVal;
    end else if (shifted < minVal) begin
      return minVal;
    end
    return shifted;
  endfunction

  // Row-major element number of W[i][j]; element 0 sits at the MSB end of
  // the flat weight vector.
  function automatic int w_idx(
    input int i,
    input int j,
    input int nin,
    input int nout
  );
    return (nout > 0) ? (i * nin + j) : 0;
  endfunction

endpackage

// File: rtl/linear_layer_bwd_seq_mac_sat.sv
// Single multiply-accumulate lane for the backward pass.
// Multiplies one weight by one delta each enabled cycle and adds it to the
// running column sum. On the last row of a column the combined sum is
// shifted and saturated for the caller and the accumulator restarts at zero.
module mac_sat
  import nn_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 0,
  parameter int ACC_W = 2 * WIDTH + 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic                    last_i,
  input  logic signed [WIDTH-1:0] weight_i,
  input  logic signed [WIDTH-1:0] delta_i,
  output logic signed [WIDTH-1:0] sat_o
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_d;

  assign prod  = (2 * WIDTH)'(weight_i) * (2 * WIDTH)'(delta_i);
  assign sum   = acc_q + ACC_W'(prod);
  assign sat_o = WIDTH'(sat_shift(SAT_W'(sum), FRAC, WIDTH));

  // Next accumulator value: cleared on a new vector or at column end, otherwise grows by one product.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = last_i ? '0 : sum;
    end
  end

  // Accumulator register, zeroed by reset so an aborted column leaves nothing behind.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/linear_layer_bwd_seq.sv
// Backward (error-propagation) pass of one dense layer.
// Computes grad[j] = relu'(j) * sum_i W[i][j] * delta[i] one MAC per cycle,
// walking rows i inside each column j, with valid/ready on both sides so it
// chains between training stages and tolerates stalls in either direction.
module linear_layer_bwd_seq
  import nn_pkg::*;
#(
  parameter int                        WIDTH               = 16,
  parameter int                        NIN                 = 2,
  parameter int                        NOUT                = 2,
  parameter int                        FRAC                = 0,
  parameter logic [WIDTH*NIN*NOUT-1:0] WEIGHTS_MATRIX_FLAT = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic signed [WIDTH-1:0] delta_in_i [0:NOUT-1],
  input  logic        [NIN-1:0]   act_mask_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [WIDTH-1:0] grad_out_o [0:NIN-1]
);

  localparam int ACC_W = 2 * WIDTH + $clog2(NOUT) + 1;
  localparam int IW    = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int JW    = (NIN > 1) ? $clog2(NIN) : 1;

  bwd_state_t              state_q, state_d;
  logic [IW-1:0]           iCnt_q;
  logic [JW-1:0]           jCnt_q;
  logic signed [WIDTH-1:0] delta_q [0:NOUT-1];
  logic [NIN-1:0]          mask_q;
  logic signed [WIDTH-1:0] grad_q [0:NIN-1];
  logic signed [WIDTH-1:0] weightSel;
  logic signed [WIDTH-1:0] deltaSel;
  logic signed [WIDTH-1:0] colSat;
  logic                    accept;
  logic                    macEn;
  logic                    colEnd;
  logic                    lastCol;

  assign accept  = in_valid_i && in_ready_o;
  assign colEnd  = macEn && (iCnt_q == IW'(NOUT - 1));
  assign lastCol = (jCnt_q == JW'(NIN - 1));

  // State register; reset always lands in IDLE and drops any vector in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: accept in IDLE, walk the matrix in MAC, wait for the consumer in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = MAC;
      MAC:     if (colEnd && lastCol) state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and enable outputs decoded from the current state; never ready while held in reset.
  always_comb begin
    in_ready_o  = rst_ni && (state_q == IDLE);
    out_valid_o = (state_q == DONE);
    macEn       = (state_q == MAC);
  end

  // Weight and delta operands picked by constant slices of the flat parameter, no weight storage.
  always_comb begin
    weightSel = '0;
    deltaSel  = '0;
    for (int ii = 0; ii < NOUT; ii++) begin
      if (iCnt_q == IW'(ii)) deltaSel = delta_q[ii];
      for (int jj = 0; jj < NIN; jj++) begin
        if (iCnt_q == IW'(ii) && jCnt_q == JW'(jj)) begin
          weightSel = WEIGHTS_MATRIX_FLAT[(NIN*NOUT - w_idx(ii, jj, NIN, NOUT))*WIDTH-1 -: WIDTH];
        end
      end
    end
  end

  mac_sat #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) uMacSat (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (accept),
    .en_i     (macEn),
    .last_i   (colEnd),
    .weight_i (weightSel),
    .delta_i  (deltaSel),
    .sat_o    (colSat)
  );

  // Vector capture, row/column counters and masked column write-back; results persist until overwritten.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      iCnt_q <= '0;
      jCnt_q <= '0;
      mask_q <= '0;
      for (int ii = 0; ii < NOUT; ii++) delta_q[ii] <= '0;
      for (int jj = 0; jj < NIN; jj++) grad_q[jj] <= '0;
    end else if (accept) begin
      iCnt_q <= '0;
      jCnt_q <= '0;
      mask_q <= act_mask_i;
      for (int ii = 0; ii < NOUT; ii++) delta_q[ii] <= delta_in_i[ii];
    end else if (macEn) begin
      if (colEnd) begin
        iCnt_q <= '0;
        jCnt_q <= lastCol ? '0 : jCnt_q + JW'(1);
        for (int jj = 0; jj < NIN; jj++) begin
          if (jCnt_q == JW'(jj)) grad_q[jj] <= mask_q[jj] ? colSat : '0;
        end
      end else begin
        iCnt_q <= iCnt_q + IW'(1);
      end
    end
  end

  assign grad_out_o = grad_q;

endmodule

// File: tb/tb_linear_layer_bwd_seq.sv
// Self-checking bench for linear_layer_bwd_seq.
// Three instances share one stimulus stream: a small integer matrix, an
// all-max matrix for saturation, and a FRAC=8 matrix for flooring. Table
// vectors pick which instance's result to check; backpressure and a reset
// in the middle of a MAC run are written out by hand.
module tb_linear_layer_bwd_seq;

  localparam int WIDTH = 16;
  localparam int NIN   = 2;
  localparam int NOUT  = 2;
  localparam logic [63:0] W_BASIC = 64'h0001_0002_0003_0004;
  localparam logic [63:0] W_SAT   = 64'h7FFF_7FFF_7FFF_7FFF;
  localparam logic [63:0] W_FRAC  = 64'hFFFF_0100_0000_0000;

  typedef struct {
    int         sel;
    int         d0;
    int         d1;
    logic [1:0] mask;
    int         e0;
    int         e1;
  } vec_t;

  logic                    clk = 1'b0;
  logic                    rstN;
  logic                    inValid;
  logic                    outReady;
  logic signed [WIDTH-1:0] delta [0:NOUT-1];
  logic        [NIN-1:0]   mask;
  logic                    inReadyA, inReadyS, inReadyF;
  logic                    outValidA, outValidS, outValidF;
  logic signed [WIDTH-1:0] gradA [0:NIN-1];
  logic signed [WIDTH-1:0] gradS [0:NIN-1];
  logic signed [WIDTH-1:0] gradF [0:NIN-1];

  int   nChecks = 0;
  int   nFails  = 0;
  vec_t vecs [12];

  // Free-running clock shared by all three instances.
  always #5 clk = ~clk;

  linear_layer_bwd_seq #(.WIDTH(WIDTH), .NIN(NIN), .NOUT(NOUT), .FRAC(0), .WEIGHTS_MATRIX_FLAT(W_BASIC)) dutA (
    .clk_i(clk), .rst_ni(rstN), .in_valid_i(inValid), .in_ready_o(inReadyA), .delta_in_i(delta),
    .act_mask_i(mask), .out_valid_o(outValidA), .out_ready_i(outReady), .grad_out_o(gradA));

  linear_layer_bwd_seq #(.WIDTH(WIDTH), .NIN(NIN), .NOUT(NOUT), .FRAC(0), .WEIGHTS_MATRIX_FLAT(W_SAT)) dutS (
    .clk_i(clk), .rst_ni(rstN), .in_valid_i(inValid), .in_ready_o(inReadyS), .delta_in_i(delta),
    .act_mask_i(mask), .out_valid_o(outValidS), .out_ready_i(outReady), .grad_out_o(gradS));

  linear_layer_bwd_seq #(.WIDTH(WIDTH), .NIN(NIN), .NOUT(NOUT), .FRAC(8), .WEIGHTS_MATRIX_FLAT(W_FRAC)) dutF (
    .clk_i(clk), .rst_ni(rstN), .in_valid_i(inValid), .in_ready_o(inReadyF), .delta_in_i(delta),
    .act_mask_i(mask), .out_valid_o(outValidF), .out_ready_i(outReady), .grad_out_o(gradF));

  function automatic int getGrad(input int sel, input int k);
    case (sel)
      1:       return int'(gradS[k]);
      2:       return int'(gradF[k]);
      default: return int'(gradA[k]);
    endcase
  endfunction

  function automatic int getValid(input int sel);
    case (sel)
      1:       return int'(outValidS);
      2:       return int'(outValidF);
      default: return int'(outValidA);
    endcase
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present one vector, let it be accepted, and count edges (accept edge included) until out_valid.
  task automatic applyStimulus(input int d0, input int d1, input logic [1:0] m, output int edges);
    @(negedge clk);
    delta[0] = 16'(d0);
    delta[1] = 16'(d1);
    mask     = m;
    inValid  = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    edges   = 1;
    while (!outValidA && edges < 50) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  // Compare the selected instance's result and latency, then complete the output handshake.
  task automatic checkOutput(input string name, input int sel, input int e0, input int e1, input int edges);
    check({name, " latency"}, edges, 5);
    check({name, " valid"}, getValid(sel), 1);
    check({name, " grad0"}, getGrad(sel, 0), e0);
    check({name, " grad1"}, getGrad(sel, 1), e1);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
  endtask

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int edges;

    vecs[0]  = '{0, 10, -1, 2'b11, 7, 16};
    vecs[1]  = '{0, 10, -1, 2'b01, 7, 0};
    vecs[2]  = '{0, 10, -1, 2'b00, 0, 0};
    vecs[3]  = '{0, 1, 1, 2'b11, 4, 6};
    vecs[4]  = '{0, -5, 2, 2'b10, 0, -2};
    vecs[5]  = '{1, 32767, 32767, 2'b11, 32767, 32767};
    vecs[6]  = '{1, -32768, -32768, 2'b11, -32768, -32768};
    vecs[7]  = '{1, 32767, -32768, 2'b11, -32767, -32767};
    vecs[8]  = '{2, 1, 0, 2'b11, -1, 1};
    vecs[9]  = '{2, 3, 0, 2'b11, -1, 3};
    vecs[10] = '{2, 0, 5, 2'b11, 0, 0};
    vecs[11] = '{2, -256, 0, 2'b11, 1, -256};

    rstN     = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    delta[0] = '0;
    delta[1] = '0;
    mask     = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready low", int'(inReadyA), 0);
    check("reset out_valid", int'(outValidA), 0);
    check("reset grad0", int'(gradA[0]), 0);
    check("reset grad1", int'(gradA[1]), 0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    check("idle in_ready", int'(inReadyA), 1);

    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].d0, vecs[v].d1, vecs[v].mask, edges);
      checkOutput($sformatf("vec%0d", v), vecs[v].sel, vecs[v].e0, vecs[v].e1, edges);
      check($sformatf("vec%0d back to idle", v), int'(inReadyA), 1);
    end

    // Backpressure: result must hold and in_valid pulses must be ignored.
    applyStimulus(10, -1, 2'b11, edges);
    check("bp latency", edges, 5);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      inValid  = (c % 2 == 0);
      delta[0] = 16'sd100;
      delta[1] = 16'sd100;
      mask     = 2'b11;
      @(posedge clk);
      #1;
      check("bp out_valid held", int'(outValidA), 1);
      check("bp in_ready low", int'(inReadyA), 0);
      check("bp grad0 stable", int'(gradA[0]), 7);
      check("bp grad1 stable", int'(gradA[1]), 16);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    check("bp release out_valid", int'(outValidA), 0);
    check("bp release in_ready", int'(inReadyA), 1);
    check("idle grad0 held", int'(gradA[0]), 7);
    check("idle grad1 held", int'(gradA[1]), 16);
    @(posedge clk);
    #1;
    check("no stray accept", int'(inReadyA), 1);

    // Reset during the second MAC cycle discards the partial result.
    @(negedge clk);
    delta[0] = 16'sd1;
    delta[1] = 16'sd1;
    mask     = 2'b11;
    inValid  = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    check("midmac busy", int'(inReadyA), 0);
    @(posedge clk);
    #1;
    rstN = 1'b0;
    @(posedge clk);
    #1;
    check("midmac rst out_valid", int'(outValidA), 0);
    check("midmac rst grad0", int'(gradA[0]), 0);
    check("midmac rst grad1", int'(gradA[1]), 0);
    check("midmac rst in_ready", int'(inReadyA), 0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    check("midmac idle", int'(inReadyA), 1);
    applyStimulus(10, -1, 2'b11, edges);
    checkOutput("after reset", 0, 7, 16, edges);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
